// File: rtl/id_ex_stage_pkg.sv
// Shared decode definitions for the ID/EX stage and the ALU: opcodes, bubble fields, operand-B select.
package id_ex_stage_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALUR = 7'b0110011;

  typedef enum logic [1:0] {
    BSEL_RS2,
    BSEL_IMM_I,
    BSEL_IMM_S
  } bsel_e;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       regwrite;
    logic       valid;
  } idex_ctrl_t;

  // A bubble is an ALUopI with every field cleared, so the ALU sees a harmless no-op.
  localparam idex_ctrl_t BUBBLE_CTRL = '{
    op:       OP_ALUI,
    funct3:   3'b000,
    funct7:   7'b0000000,
    rd:       5'd0,
    regwrite: 1'b0,
    valid:    1'b0
  };

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_ALUI) || (op == OP_ALUR);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the decode/ID-EX stage (master) and the surrounding pipeline (slave).
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [31:0]      IFIDinstr;
  logic             IFIDvalid;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [4:0]       EXMEMrd;
  logic [4:0]       MEMWBrd;
  logic             EXMEMregwrite;
  logic             MEMWBregwrite;
  logic [XLEN-1:0]  EXMEMALUOut;
  logic [XLEN-1:0]  MEMWBvalue;
  logic             flush;
  logic             hold;
  logic [6:0]       IDEXop;
  logic [2:0]       IDEXfunct3;
  logic [6:0]       IDEXfunct7;
  logic [XLEN-1:0]  IDEXA;
  logic [XLEN-1:0]  IDEXB;
  logic [XLEN-1:0]  IDEXstore;
  logic [4:0]       IDEXrd;
  logic             IDEXregwrite;
  logic             IDEXvalid;
  logic             IDEXillegal;
  logic             IFIDstall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  IFIDinstr, IFIDvalid, rs1_data, rs2_data,
    input  EXMEMrd, MEMWBrd, EXMEMregwrite, MEMWBregwrite, EXMEMALUOut, MEMWBvalue,
    input  flush, hold,
    output rs1_addr, rs2_addr,
    output IDEXop, IDEXfunct3, IDEXfunct7, IDEXA, IDEXB, IDEXstore,
    output IDEXrd, IDEXregwrite, IDEXvalid, IDEXillegal, IFIDstall, stall_count
  );

  modport slave (
    output IFIDinstr, IFIDvalid, rs1_data, rs2_data,
    output EXMEMrd, MEMWBrd, EXMEMregwrite, MEMWBregwrite, EXMEMALUOut, MEMWBvalue,
    output flush, hold,
    input  rs1_addr, rs2_addr,
    input  IDEXop, IDEXfunct3, IDEXfunct7, IDEXA, IDEXB, IDEXstore,
    input  IDEXrd, IDEXregwrite, IDEXvalid, IDEXillegal, IFIDstall, stall_count
  );
endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// imm_gen: combinational I/S immediate extraction with sign extension, plus the operand-B source.
module id_ex_stage_imm_gen
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output bsel_e           bsel
);

  logic [6:0] op;
  logic       unused_bits;

  assign op          = instr[6:0];
  assign unused_bits = ^instr[19:12];

  always_comb begin
    bsel = BSEL_IMM_I;
    if (op == OP_ALUR) begin
      bsel = BSEL_RS2;
    end else if (op == OP_SW) begin
      bsel = BSEL_IMM_S;
    end
  end

  always_comb begin
    imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    if (bsel == BSEL_IMM_S) begin
      imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX register: operand select, load-use bubble insertion, flush/hold.
// Define IDEX_FWD_EN to forward EX/MEM and MEM/WB results into the operands.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic            clock,
  input logic            reset,
  id_ex_stage_if.master  bus
);

  logic [6:0]       op;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             uses_rs2;
  logic [XLEN-1:0]  imm;
  bsel_e            bsel;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic             hazard;

  idex_ctrl_t       ctrl_q, ctrl_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  store_q, store_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign op           = bus.IFIDinstr[6:0];
  assign rs1          = bus.IFIDinstr[19:15];
  assign rs2          = bus.IFIDinstr[24:20];
  assign bus.rs1_addr = rs1;
  assign bus.rs2_addr = rs2;
  assign uses_rs2     = (op == OP_ALUR) || (op == OP_SW);

  id_ex_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (bus.IFIDinstr),
    .imm   (imm),
    .bsel  (bsel)
  );

`ifdef IDEX_FWD_EN
  // The younger result (EX/MEM) wins over MEM/WB when both target the same register.
  always_comb begin
    rs1_val = bus.rs1_data;
    if (bus.EXMEMregwrite && (bus.EXMEMrd != 5'd0) && (bus.EXMEMrd == rs1)) begin
      rs1_val = bus.EXMEMALUOut;
    end else if (bus.MEMWBregwrite && (bus.MEMWBrd != 5'd0) && (bus.MEMWBrd == rs1)) begin
      rs1_val = bus.MEMWBvalue;
    end
  end

  always_comb begin
    rs2_val = bus.rs2_data;
    if (bus.EXMEMregwrite && (bus.EXMEMrd != 5'd0) && (bus.EXMEMrd == rs2)) begin
      rs2_val = bus.EXMEMALUOut;
    end else if (bus.MEMWBregwrite && (bus.MEMWBrd != 5'd0) && (bus.MEMWBrd == rs2)) begin
      rs2_val = bus.MEMWBvalue;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.EXMEMrd, bus.MEMWBrd, bus.EXMEMregwrite, bus.MEMWBregwrite,
                        bus.EXMEMALUOut, bus.MEMWBvalue};
  assign rs1_val    = bus.rs1_data;
  assign rs2_val    = bus.rs2_data;
`endif

  // rs2 only counts as a source for the formats that actually read it; I-type bits 24:20 are immediate.
  assign hazard = ctrl_q.valid && (ctrl_q.op == OP_LW) && (ctrl_q.rd != 5'd0) && bus.IFIDvalid &&
                  ((ctrl_q.rd == rs1) || (uses_rs2 && (ctrl_q.rd == rs2)));

  assign bus.IFIDstall = !reset && !bus.flush && (bus.hold || hazard);

  always_comb begin
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    store_d     = store_q;
    illegal_d   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      ctrl_d  = BUBBLE_CTRL;
      a_d     = '0;
      b_d     = '0;
      store_d = '0;
    end else if (bus.hold) begin
      ctrl_d = ctrl_q;
    end else if (hazard) begin
      ctrl_d      = BUBBLE_CTRL;
      a_d         = '0;
      b_d         = '0;
      store_d     = '0;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (!bus.IFIDvalid || !op_supported(op)) begin
      ctrl_d    = BUBBLE_CTRL;
      a_d       = '0;
      b_d       = '0;
      store_d   = '0;
      illegal_d = bus.IFIDvalid;
    end else begin
      ctrl_d.op       = op;
      ctrl_d.funct3   = bus.IFIDinstr[14:12];
      ctrl_d.funct7   = ((op == OP_ALUR) || (op == OP_ALUI)) ? bus.IFIDinstr[31:25] : 7'd0;
      ctrl_d.rd       = (op == OP_SW) ? 5'd0 : bus.IFIDinstr[11:7];
      ctrl_d.regwrite = (op != OP_SW);
      ctrl_d.valid    = 1'b1;
      a_d             = rs1_val;
      b_d             = (bsel == BSEL_RS2) ? rs2_val : imm;
      store_d         = (op == OP_SW) ? rs2_val : '0;
    end
  end

  // ID/EX register boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      store_q     <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      store_q     <= store_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.IDEXop       = ctrl_q.op;
  assign bus.IDEXfunct3   = ctrl_q.funct3;
  assign bus.IDEXfunct7   = ctrl_q.funct7;
  assign bus.IDEXrd       = ctrl_q.rd;
  assign bus.IDEXregwrite = ctrl_q.regwrite;
  assign bus.IDEXvalid    = ctrl_q.valid;
  assign bus.IDEXA        = a_q;
  assign bus.IDEXB        = b_q;
  assign bus.IDEXstore    = store_q;
  assign bus.IDEXillegal  = illegal_q;
  assign bus.stall_count  = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register that feeds the ALU. It decodes the IF/ID instruction and selects the ALU operands, with immediate selection and sign extension. It registers op/funct3/funct7/operands/rd for the EX stage, detects load-use hazards, and inserts bubbles. It also handles flush and downstream hold requests.

## Interface
- Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the saturating load-use stall counter
- Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- IFIDinstr  in  32  instruction from IF/ID
- IFIDvalid  in  1  IF/ID holds a real instruction
- rs1_addr, rs2_addr  out  5 each  register-file read addresses, combinational from IFIDinstr[19:15], [24:20]
- rs1_data, rs2_data  in  XLEN each  register-file read data, same cycle
- EXMEMrd, MEMWBrd  in  5 each  destination of the instructions in MEM and WB
- EXMEMregwrite, MEMWBregwrite  in  1 each  those instructions write a register
- EXMEMALUOut, MEMWBvalue  in  XLEN each  forwardable results
- flush  in  1  kill the instruction entering EX
- hold  in  1  downstream busy; freeze the ID/EX register
- IDEXop  out  7  opcode to ALU
- IDEXfunct3  out  3  funct3 to ALU
- IDEXfunct7  out  7  funct7 to ALU
- IDEXA, IDEXB  out  XLEN each  ALU operands Ain/Bin
- IDEXstore  out  XLEN  SW store data (rs2 value)
- IDEXrd  out  5  destination register
- IDEXregwrite  out  1  EX instruction writes rd
- IDEXvalid  out  1  EX holds a real instruction
- IDEXillegal  out  1  one-cycle pulse: unsupported opcode decoded
- IFIDstall  out  1  combinational; IF/ID must hold its contents this cycle
- stall_count  out  CNT_W  saturating count of load-use bubbles

## Operation
- Supported opcodes: LW 0000011, SW 0100011, ALUopI 0010011, ALUopR 0110011.
- Immediates: I-type {20×instr[31], instr[31:20]}; S-type {20×instr[31], instr[31:25], instr[11:7]}.
- Operand select: IDEXA = rs1 value. IDEXB = rs2 value for ALUopR and the immediate otherwise. IDEXstore = rs2 value for SW and 0 otherwise.
- Register write: IDEXregwrite = 1 for LW/ALUopI/ALUopR and 0 for SW. IDEXrd = instr[11:7], or 0 for SW.
- funct7 is passed through as instr[31:25] for ALUopR and ALUopI, and is 0 for LW/SW.
- Bubble: IDEXop = ALUopI, funct3 = 0, funct7 = 0, A = B = store = 0, rd = 0, regwrite = 0, valid = 0.
- Load-use hazard: the instruction in EX must satisfy all of IDEXvalid, IDEXop == LW and IDEXrd != 0. The incoming instruction must satisfy IFIDvalid. IDEXrd must equal rs1, or equal rs2 when the incoming op is ALUopR or SW.
- Per-cycle priority, highest first:
  - reset: all outputs zero (IDEXop = 0, stall_count = 0, IFIDstall = 0).
  - flush: load a bubble; IFIDstall = 0.
  - hold: ID/EX register unchanged; IFIDstall = 1.
  - load-use hazard: load a bubble, IFIDstall = 1, stall_count += 1 (saturates at all-ones).
  - IFIDvalid = 0: load a bubble.
  - unsupported opcode: load a bubble and pulse IDEXillegal.
  - otherwise: load the decoded instruction with IDEXvalid = 1.
- IDEXillegal is registered and is 0 in every cycle except the one following an illegal decode.

## Timing
- Decode to EX latency is one cycle: the IF/ID contents at edge N appear on the IDEX* outputs after edge N.
- A load-use hazard costs exactly one bubble. On the next cycle the EX instruction is the bubble, so the hazard clears and the held instruction advances.
- IFIDstall is combinational from IFIDinstr, IFIDvalid, the ID/EX register, hold and flush. It has no registered delay.
- flush and hold asserted together: flush wins.
- Reset asserted mid-stall: the next cycle shows reset values and no pending stall.

## Configuration
- IDEX_FWD_EN defined:
  - rs1 and rs2 values are forwarded into IDEXA, IDEXB and IDEXstore.
  - A source qualifies when its regwrite is set, its rd is nonzero and its rd equals rs1 or rs2.
  - EX/MEM has priority over MEM/WB, which has priority over rs*_data.
- IDEX_FWD_EN undefined: rs1_data and rs2_data are used raw and the forwarding inputs are ignored. Load-use detection is unchanged in both builds.

## Structure
- The opcode constants live in the shared opcode package/include used by the ALU.
- The shared package also holds:
  - the bubble field values
  - an enum for the operand-B source: RS2, IMM_I, IMM_S
- One sub-module, imm_gen: combinational immediate extraction and sign extension from the instruction and opcode.

## Test plan
- ALUopR ADD x3,x1,x2 with rs1_data = 5, rs2_data = 7 -> next cycle: IDEXop = 0110011, funct3 = 000, funct7 = 0, A = 5, B = 7, rd = 3, valid = 1.
- SW with offset -4 (instr[31:25] = 1111111, [11:7] = 11100) -> IDEXB = 0xFFFFFFFC, IDEXstore = rs2_data, regwrite = 0.
- LW x5 in EX followed by ADD x6,x5,x1 -> IFIDstall = 1 for one cycle, one bubble, stall_count = 1; ADD enters EX the cycle after.
- LW x0 in EX followed by a consumer of x0 -> no stall; flush together with a hazard -> bubble, IFIDstall = 0, stall_count unchanged.
- With IDEX_FWD_EN, EXMEMrd = MEMWBrd = 1, EXMEMALUOut = 0xAA, MEMWBvalue = 0xBB, rs1 = 1 -> IDEXA = 0xAA. Without IDEX_FWD_EN -> IDEXA = rs1_data.
- Opcode 1111111 -> bubble with IDEXillegal = 1 for one cycle; hold for 3 cycles -> IDEX outputs stable and IFIDstall = 1 throughout.
